signal_range_tracker: RTL and testbench

- Records the clock-stamped history of a narrow tracked signal in a DEPTH-entry circular buffer.
- Answers range queries: was the signal asserted at any timestamp within a requested window?
- Used by pipeline-stage trace trackers to reconstruct past control events, e.g. jump_done or illegal_instruction, after the fact.
- Stamps come from the shared free-running cycle counter.

---
 rtl/tracker_pkg.sv | 10 +
 rtl/tracker_history_ring.sv | 41 ++++
 rtl/signal_range_tracker.sv | 70 +++++++
 tb/tb_signal_range_tracker.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tracker_pkg.sv
// rtl/tracker_pkg.sv - shared timestamp types and constants for the trace trackers
package tracker_pkg;

  typedef logic signed [31:0] timestamp_t;
  typedef timestamp_t [1:0] time_range_t;

  // Sentinel returned by sibling trackers when no matching event exists.
  localparam timestamp_t TRACKER_NOT_FOUND = -1;

endpackage

// File: rtl/tracker_history_ring.sv
// rtl/tracker_history_ring.sv - circular store of asserted-sample timestamps with valid bits
module tracker_history_ring
  import tracker_pkg::*;
#(
  parameter int DEPTH = 128
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  timestamp_t         wr_stamp,
  output logic [DEPTH*32-1:0] stamps_flat,
  output logic [DEPTH-1:0]   valid
);

  localparam int PTR_W = $clog2(DEPTH);

  timestamp_t       stamps [DEPTH];
  logic [PTR_W-1:0] wr_ptr;

  // Pointer wraps naturally because DEPTH is a power of two; oldest slot is overwritten.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid  <= '0;
      wr_ptr <= '0;
    end else if (wr_en) begin
      valid[wr_ptr] <= 1'b1;
      wr_ptr        <= wr_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      stamps[wr_ptr] <= wr_stamp;
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_flat
    assign stamps_flat[i*32 +: 32] = stamps[i];
  end

endmodule

// File: rtl/signal_range_tracker.sv
// rtl/signal_range_tracker.sv - records asserted timestamps and answers window hit queries
// Optional live-sample bypass: SIGNAL_RANGE_TRACKER_BYPASS_EN.
module signal_range_tracker
  import tracker_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int DEPTH = 128
) (
  input  logic               clk,
  input  logic               rst,
  input  logic signed [31:0] counter,
  input  logic [WIDTH-1:0]   tracked_signal,
  input  logic signed [31:0] range_in [1:0],
  input  logic               recalculate_range,
  output logic               range_out
);

  logic [DEPTH*32-1:0] stamps_flat;
  logic [DEPTH-1:0]    valid;
  logic                sample_hit;
  timestamp_t          lo;
  timestamp_t          hi;
  logic                match;
  logic                hold_q;

  assign sample_hit = |tracked_signal;

  tracker_history_ring #(
    .DEPTH (DEPTH)
  ) u_ring (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (sample_hit),
    .wr_stamp    (counter),
    .stamps_flat (stamps_flat),
    .valid       (valid)
  );

  always_comb begin
    lo = (range_in[0] < range_in[1]) ? range_in[0] : range_in[1];
    hi = (range_in[0] < range_in[1]) ? range_in[1] : range_in[0];
  end

  // The ring only updates on the edge, so this search never sees the current cycle's write.
  always_comb begin
    match = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i] && ($signed(stamps_flat[i*32 +: 32]) >= lo) &&
          ($signed(stamps_flat[i*32 +: 32]) <= hi)) begin
        match = 1'b1;
      end
    end
`ifdef SIGNAL_RANGE_TRACKER_BYPASS_EN
    if (sample_hit && (counter >= lo) && (counter <= hi)) begin
      match = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q <= 1'b0;
    end else if (recalculate_range) begin
      hold_q <= match;
    end
  end

  assign range_out = recalculate_range ? match : hold_q;

endmodule

// File: tb/tb_signal_range_tracker.sv
// tb/tb_signal_range_tracker.sv - self-checking bench for signal_range_tracker
module tb_signal_range_tracker;

  localparam int WIDTH = 2;
  localparam int DEPTH = 128;

  logic               clk = 1'b0;
  logic               rst;
  logic signed [31:0] counter;
  logic [WIDTH-1:0]   tracked_signal;
  logic signed [31:0] range_in [1:0];
  logic               recalculate_range;
  logic               range_out;

  int checks = 0;
  int errors = 0;

  // Reference: the last DEPTH asserted timestamps plus the last registered answer.
  int model_q[$];
  bit model_hold;

  signal_range_tracker #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .counter           (counter),
    .tracked_signal    (tracked_signal),
    .range_in          (range_in),
    .recalculate_range (recalculate_range),
    .range_out         (range_out)
  );

  always #5 clk = ~clk;

  function automatic bit model_match();
    int lo;
    int hi;
    lo = (range_in[0] < range_in[1]) ? range_in[0] : range_in[1];
    hi = (range_in[0] < range_in[1]) ? range_in[1] : range_in[0];
    foreach (model_q[i]) begin
      if (model_q[i] >= lo && model_q[i] <= hi) return 1'b1;
    end
`ifdef SIGNAL_RANGE_TRACKER_BYPASS_EN
    if (tracked_signal != 0 && counter >= lo && counter <= hi) return 1'b1;
`endif
    return 1'b0;
  endfunction

  function automatic bit expected_out();
    if (rst) return 1'b0;
    return recalculate_range ? model_match() : model_hold;
  endfunction

  task automatic tick();
    @(posedge clk);
    if (!rst) begin
      if (recalculate_range) model_hold = model_match();
      if (tracked_signal != 0) begin
        model_q.push_back(counter);
        if (model_q.size() > DEPTH) void'(model_q.pop_front());
      end
    end
    #1;
    counter = counter + 1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_q.delete();
    model_hold = 1'b0;
    tracked_signal = '0;
    recalculate_range = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    counter = 0;
  endtask

  task automatic set_window(input int first, input int second);
    range_in[1] = first;
    range_in[0] = second;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    counter = 0;
    tracked_signal = '0;
    set_window(10, 20);
    recalculate_range = 1'b1;
    #2;
    if (range_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_active: range_out=%0b expected=0", range_out);
    end
    checks++;
    tick();
    tick();
    rst = 1'b0;
    model_q.delete();
    model_hold = 1'b0;
    #3;
    if (range_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_strobe: range_out=%0b expected=0", range_out);
    end
    checks++;
    tick();
    recalculate_range = 1'b0;
    #3;
    if (range_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_held: range_out=%0b expected=0", range_out);
    end
    checks++;
  endtask

  task automatic test_single_hit();
    int win_a [4] = '{10, 16, 15, 20};
    int win_b [4] = '{20, 30, 15, 10};
    bit exp_r [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    do_reset();
    while (counter <= 30) begin
      tracked_signal = (counter == 15) ? 2'b10 : 2'b00;
      tick();
    end
    tracked_signal = '0;
    for (int k = 0; k < 4; k++) begin
      set_window(win_a[k], win_b[k]);
      recalculate_range = 1'b1;
      #3;
      if (range_out !== exp_r[k]) begin
        errors++;
        $display("FAIL single_hit[%0d] {%0d,%0d}: range_out=%0b expected=%0b",
                 k, win_a[k], win_b[k], range_out, exp_r[k]);
      end
      checks++;
      tick();
    end
  endtask

  task automatic test_hold();
    set_window(10, 20);
    recalculate_range = 1'b1;
    tick();
    recalculate_range = 1'b0;
    set_window(100, 200);
    for (int k = 0; k < 3; k++) begin
      #3;
      if (range_out !== 1'b1) begin
        errors++;
        $display("FAIL hold[%0d]: range_out=%0b expected=1", k, range_out);
      end
      checks++;
      tick();
    end
    recalculate_range = 1'b1;
    #3;
    if (range_out !== 1'b0) begin
      errors++;
      $display("FAIL hold_restrobe: range_out=%0b expected=0", range_out);
    end
    checks++;
    tick();
    recalculate_range = 1'b0;
    #3;
    if (range_out !== 1'b0) begin
      errors++;
      $display("FAIL hold_after_restrobe: range_out=%0b expected=0", range_out);
    end
    checks++;
  endtask

  task automatic test_wrap();
    int win_a [5] = '{0, 72, 200, 71, 72};
    int win_b [5] = '{71, 199, 300, 71, 72};
    bit exp_r [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    do_reset();
    tracked_signal = 2'b01;
    repeat (200) tick();
    tracked_signal = '0;
    for (int k = 0; k < 5; k++) begin
      set_window(win_a[k], win_b[k]);
      recalculate_range = 1'b1;
      #3;
      if (range_out !== exp_r[k]) begin
        errors++;
        $display("FAIL wrap[%0d] {%0d,%0d}: range_out=%0b expected=%0b",
                 k, win_a[k], win_b[k], range_out, exp_r[k]);
      end
      checks++;
      tick();
    end
  endtask

  task automatic test_async_reset_mid_query();
    do_reset();
    while (counter <= 10) begin
      tracked_signal = (counter == 5) ? 2'b11 : 2'b00;
      tick();
    end
    tracked_signal = '0;
    set_window(0, 10);
    recalculate_range = 1'b1;
    #3;
    if (range_out !== 1'b1) begin
      errors++;
      $display("FAIL midq_before: range_out=%0b expected=1", range_out);
    end
    checks++;
    #1;
    rst = 1'b1;
    model_q.delete();
    model_hold = 1'b0;
    #1;
    if (range_out !== 1'b0) begin
      errors++;
      $display("FAIL midq_during: range_out=%0b expected=0", range_out);
    end
    checks++;
    tick();
    tick();
    rst = 1'b0;
    #3;
    if (range_out !== 1'b0) begin
      errors++;
      $display("FAIL midq_after: range_out=%0b expected=0", range_out);
    end
    checks++;
    tick();
    recalculate_range = 1'b0;
    #3;
    if (range_out !== 1'b0) begin
      errors++;
      $display("FAIL midq_after_held: range_out=%0b expected=0", range_out);
    end
    checks++;
  endtask

  task automatic test_random();
    bit exp_v;
    do_reset();
    // Start just below the signed maximum so timestamps cross the wrap.
    counter = 32'sh7FFF_FE80;
    for (int n = 0; n < 700; n++) begin
      tracked_signal = ($urandom_range(0, 1) == 0) ? WIDTH'($urandom_range(1, 3)) : '0;
      recalculate_range = 1'($urandom_range(0, 1));
      range_in[1] = counter - $urandom_range(0, 400);
      range_in[0] = counter - $urandom_range(0, 400);
      #3;
      exp_v = expected_out();
      if (range_out !== exp_v) begin
        errors++;
        $display("FAIL random[%0d] ctr=%0d {%0d,%0d} strobe=%0b: range_out=%0b expected=%0b",
                 n, counter, range_in[1], range_in[0], recalculate_range, range_out, exp_v);
      end
      checks++;
      tick();
    end
  endtask

  initial begin
    rst = 1'b1;
    counter = 0;
    tracked_signal = '0;
    recalculate_range = 1'b0;
    range_in[0] = 0;
    range_in[1] = 0;
    model_hold = 1'b0;
    test_reset();
    test_single_hit();
    test_hold();
    test_wrap();
    test_async_reset_mid_query();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
